// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmitter: frame-length constants, the
// transmitter state encoding and the parity helper.
// Optional feature macro: UART_TX_PARITY_EN (adds one even-parity bit per frame).
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // start + data + optional parity + stop
  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + STOP_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// -----------------------------------------------------------------------------
// baud_gen
// Bit-period counter for the UART transmitter. Counts 0..BIT_CYC-1 and
// restarts from 0 either on its own at the end of a period or when clr is
// asserted by the owning FSM.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   force the count back to 0 on the next edge
//   bit_done out  high during the last cycle of a bit period
// -----------------------------------------------------------------------------
module baud_gen #(
  parameter int BIT_CYC = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_done
);

  // A one-cycle bit period would give a zero-width counter; keep one bit.
  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

  logic [CW-1:0] r_cnt;

  assign bit_done = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || bit_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8-bit UART transmitter, LSB first, one stop bit. The serial line is driven
// straight from a flop, so the output is glitch-free and changes one cycle
// after the FSM decision that produced it.
// Optional feature macro: UART_TX_PARITY_EN -- inserts one even-parity bit
// between the data bits and the stop bit (11-bit frame instead of 10).
// Parameters:
//   CLK_FREQ   system clock in Hz
//   BAUD_RATE  line rate in bit/s; each bit lasts CLK_FREQ/BAUD_RATE cycles
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   tx_data   in   byte to send, sampled on the accept edge only
//   tx_valid  in   requester has a byte
//   tx_ready  out  idle, a byte offered now is accepted on the next edge
//   tx_uart   out  serial line, idle high
//   tx_busy   out  frame in progress
// -----------------------------------------------------------------------------
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_uart,
  output logic       tx_busy
);

  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

  state_e     r_state, w_state_nxt;
  logic [2:0] r_bit_idx, w_bit_idx_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_tx, w_tx_nxt;
  logic       r_ready;
  logic       r_busy;
`ifdef UART_TX_PARITY_EN
  logic       r_parity, w_parity_nxt;
`endif

  logic w_accept;
  logic w_bit_done;
  logic w_clr;

  assign w_accept = tx_valid & r_ready;

  // Hold the bit timer at zero while idle and restart it on every state
  // change so each state gets a full, aligned bit period.
  assign w_clr = (r_state == ST_IDLE) || (w_state_nxt != r_state);

  baud_gen #(
    .BIT_CYC (BIT_CYC)
  ) u_baud_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_clr),
    .bit_done (w_bit_done)
  );

  // Next-state logic. w_tx_nxt is the line level for the state being
  // entered, so the registered line lines up with the state register.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt   = ST_START;
          w_shift_nxt   = tx_data;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = 1'b0;
`ifdef UART_TX_PARITY_EN
          // Parity is taken now because the shift register is consumed.
          w_parity_nxt  = even_parity(tx_data);
`endif
        end
      end
      ST_START: begin
        if (w_bit_done) begin
          w_state_nxt   = ST_DATA;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          if (r_bit_idx == LAST_DATA_IDX) begin
            w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt   = ST_PARITY;
            w_tx_nxt      = r_parity;
`else
            w_state_nxt   = ST_STOP;
            w_tx_nxt      = 1'b1;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_tx_nxt      = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_done) begin
          w_state_nxt   = ST_STOP;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_done) begin
          // The bit index doubles as the stop-bit counter.
          if (r_bit_idx == LAST_STOP_IDX) begin
            w_state_nxt   = ST_IDLE;
            w_bit_idx_nxt = '0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_bit_idx_nxt = '0;
        w_tx_nxt      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      // Ready/busy are registered from the next state: both stay low in
      // reset and ready rises on the first edge after release.
      r_ready   <= (w_state_nxt == ST_IDLE);
      r_busy    <= (w_state_nxt != ST_IDLE);
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  assign tx_uart  = r_tx;
  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx at CLK_FREQ=1000, BAUD_RATE=100 (10 cycles
// per bit). A queue-based model expands every accepted byte into its expected
// per-cycle line levels; a compare process checks line/ready/busy every cycle.
// Directed frames pin the model with hand-computed literal bit patterns, then
// a randomized phase drives random valid/data and random resets.
// Honors UART_TX_PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int BIT_CYC   = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * BIT_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_uart, tx_busy;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_uart  (tx_uart),
    .tx_busy  (tx_busy)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted byte becomes NBITS*BIT_CYC queued line levels; one is
  // consumed per clock. Idle (ready) means the queue is exhausted.
  bit   exp_q[$];
  logic m_line  = 1'b1;
  logic m_ready = 1'b0;
  logic m_busy  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_line  <= 1'b1;
      m_ready <= 1'b0;
      m_busy  <= 1'b0;
    end else begin
      if (m_ready && tx_valid) begin
        for (int c = 0; c < BIT_CYC; c++) exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int c = 0; c < BIT_CYC; c++) exp_q.push_back(tx_data[b]);
`ifdef UART_TX_PARITY_EN
        for (int c = 0; c < BIT_CYC; c++) exp_q.push_back(^tx_data);
`endif
        for (int c = 0; c < BIT_CYC; c++) exp_q.push_back(1'b1);
      end
      if (exp_q.size() > 0) begin
        m_line  <= exp_q.pop_front();
        m_ready <= 1'b0;
        m_busy  <= 1'b1;
      end else begin
        m_line  <= 1'b1;
        m_ready <= 1'b1;
        m_busy  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_line",  tx_uart,  m_line);
      chk("cyc_ready", tx_ready, m_ready);
      chk("cyc_busy",  tx_busy,  m_busy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) chk("ready_timeout", tx_ready, 1);
  endtask

  // Sends one byte and samples the line mid-bit. k counts negedges after
  // the accept edge (k=0 is the first cycle of the start bit).
  task automatic send_frame(input logic [7:0] d, input bit pulse_mid,
                            output logic [10:0] bits, output int low);
    wait_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    bits = '1;
    low  = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end
      if (pulse_mid && k == 30) begin
        tx_valid = 1'b1;
        tx_data  = 8'h12;
      end
      if (pulse_mid && k == 31) tx_valid = 1'b0;
      if ((k % BIT_CYC) == 5 && (k / BIT_CYC) < 11) bits[k / BIT_CYC] = tx_uart;
      if (tx_ready) break;
      low++;
    end
  endtask

  logic [10:0] bits;
  int          low;
  int          hold;

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_line",  tx_uart,  1);
    chk("rst_ready", tx_ready, 0);
    chk("rst_busy",  tx_busy,  0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", tx_ready, 1);

    // 0x55 frame
    send_frame(8'h55, 1'b0, bits, low);
`ifdef UART_TX_PARITY_EN
    chk("f55_bits", bits[NBITS-1:0], 11'h4AA);
`else
    chk("f55_bits", bits[NBITS-1:0], 10'h2AA);
`endif
    chk("f55_low", low, FRAME_CYC);

    // 0xA3 frame with an ignored valid pulse of 0x12 mid-frame
    send_frame(8'hA3, 1'b1, bits, low);
`ifdef UART_TX_PARITY_EN
    chk("fA3_bits", bits[NBITS-1:0], 11'h546);
`else
    chk("fA3_bits", bits[NBITS-1:0], 10'h346);
`endif
    chk("fA3_low", low, FRAME_CYC);

    // back-to-back 0x00 then 0xFF with valid held
    wait_ready();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    for (int k = 0; k < FRAME_CYC + 100; k++) begin
      @(negedge clk);
      if (k == 0) tx_data = 8'hFF;
      if (k == 15) chk("b2b_d0_zero", tx_uart, 0);
      if (k == FRAME_CYC) begin
        chk("b2b_gap_line",  tx_uart,  1);
        chk("b2b_gap_ready", tx_ready, 1);
      end
      if (k == FRAME_CYC + 1) begin
        chk("b2b_start", tx_uart, 0);
        tx_valid = 1'b0;
      end
      for (int i = 0; i < 8; i++)
        if (k == FRAME_CYC + 1 + BIT_CYC * (i + 1) + 5) chk("b2b_data_one", tx_uart, 1);
    end

    // reset at cycle 35 of a 0x0F frame
    wait_ready();
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      if (k == 0) tx_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst35_line",  tx_uart,  1);
    chk("rst35_busy",  tx_busy,  0);
    chk("rst35_ready", tx_ready, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // reset during the start bit: line must rise without a clock edge
    wait_ready();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0) tx_valid = 1'b0;
    end
    chk("pre_rst_start", tx_uart, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_line", tx_uart, 1);
    chk("async_busy", tx_busy, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // 0x81 after reset
    send_frame(8'h81, 1'b0, bits, low);
`ifdef UART_TX_PARITY_EN
    chk("f81_bits", bits[NBITS-1:0], 11'h502);
`else
    chk("f81_bits", bits[NBITS-1:0], 10'h302);
`endif
    chk("f81_low", low, FRAME_CYC);

    // randomized traffic with occasional resets
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      if (hold > 0) begin
        hold--;
        if (hold == 0) #2 rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        hold = 2;
      end
    end
    tx_valid = 1'b0;
    if (!rst_n) begin
      @(negedge clk);
      #2 rst_n = 1'b1;
    end
    wait_ready();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
